// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational 32-bit ALU: request FIFO, head presented
// to the ALU, result captured into a single valid/ready output slot.
module alu_issue_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_carryout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned MAX_OP = 9;
  localparam int unsigned DIV_OP = 9;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STALL
  } state_e;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty;
  logic              push;
  logic              pop;
  logic              illegal_op;
  logic              div_zero;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_carry_q, out_carry_d;
  logic              out_zero_q, out_zero_d;
  logic              out_err_q, out_err_d;
  state_e            state_q, state_d;

  // Handshake qualifiers; in_ready looks at occupancy only so there is no path from out_ready
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid_q || out_ready);

  assign head    = mem_q[rd_ptr_q];
  assign alu_a   = empty ? '0 : head.a;
  assign alu_b   = empty ? '0 : head.b;
  assign alu_sel = empty ? '0 : head.sel;

  assign illegal_op = (head.sel > SEL_W'(MAX_OP));
  assign div_zero   = (head.sel == SEL_W'(DIV_OP)) && (head.b == '0);

  // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Output slot: load on pop, clear on drain, otherwise hold
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_err_d    = out_err_q;
    if (pop) begin
      out_valid_d = 1'b1;
      if (illegal_op) begin
        out_result_d = '0;
        out_carry_d  = 1'b0;
        out_zero_d   = 1'b1;
        out_err_d    = 1'b1;
      end else if (div_zero) begin
        out_result_d = '1;
        out_carry_d  = 1'b1;
        out_zero_d   = 1'b0;
        out_err_d    = 1'b1;
      end else begin
        out_result_d = alu_result;
        out_carry_d  = alu_carryout;
        out_zero_d   = (alu_result == '0);
        out_err_d    = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Flow-control state; tracks whether the queue is idle, flowing or held by the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (out_valid_q && !out_ready) begin
          state_d = ST_STALL;
        end else if ((count_d == '0) && !out_valid_d) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (out_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
      state_q      <= state_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_t'{sel: in_sel, b: in_b, a: in_a};
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small behavioural ALU closing the loop.
module tb_alu_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_err;
  logic [2:0]  count;

  int checks;
  int errors;

  alu_issue_queue #(.DATA_W(32), .SEL_W(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sel       (in_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_err      (out_err),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU
  always_comb begin
    case (alu_sel)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = alu_a << alu_b[4:0];
      4'd6:    alu_result = alu_a >> alu_b[4:0];
      4'd7:    alu_result = {31'd0, (alu_a < alu_b)};
      4'd8:    alu_result = alu_a * alu_b;
      4'd9:    alu_result = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_carryout = alu_result[31];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one op into an idle queue, check the loaded slot, then drain it
  task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic [31:0] exp_res,
                           input logic exp_c, input logic exp_z, input logic exp_e);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_sel    = sel;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_flags"}, {29'd0, out_carry, out_zero, out_err}, {29'd0, exp_c, exp_z, exp_e});
    step();
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_sel    = 4'd0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", out_result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    step();

    // Single add: one cycle in the FIFO, loaded the following edge
    in_valid  = 1'b1;
    in_a      = 32'd32;
    in_b      = 32'd32;
    in_sel    = 4'd0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("add_queued_count", {29'd0, count}, 32'd1);
    check("add_head_a", alu_a, 32'd32);
    check("add_not_yet_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd64);
    check("add_flags", {29'd0, out_carry, out_zero, out_err}, 32'd0);
    check("add_count", {29'd0, count}, 32'd0);
    step();
    check("add_drain", {31'd0, out_valid}, 32'd0);

    single_op("sub_neg", 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    single_op("xor_zero", 32'd5, 32'd5, 4'd4, 32'd0, 1'b0, 1'b1, 1'b0);
    single_op("illegal12", 32'd3, 32'd4, 4'd12, 32'd0, 1'b0, 1'b1, 1'b1);
    single_op("illegal10", 32'd3, 32'd4, 4'd10, 32'd0, 1'b0, 1'b1, 1'b1);
    single_op("div_zero", 32'd7, 32'd0, 4'd9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    single_op("div_ok", 32'd7, 32'd2, 4'd9, 32'd3, 1'b0, 1'b0, 1'b0);

    // Backpressure: five adds, one lands in the slot and four fill the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i * 10);
      in_b     = 32'd1;
      in_sel   = 4'd0;
      step();
    end
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_count", {29'd0, count}, 32'd4);
    check("bp_held_result", out_result, 32'd1);
    in_a = 32'd99;
    step();
    check("bp_reject_count", {29'd0, count}, 32'd4);
    check("bp_hold_result", out_result, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("bp_order_result", out_result, 32'(k * 10 + 1));
      check("bp_order_count", {29'd0, count}, 32'(4 - k));
    end
    step();
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Streaming: one op in and one result out per cycle, wrapping the pointers
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i);
      in_b     = 32'(2 * i);
      in_sel   = 4'd0;
      step();
      if (i > 0) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_result", out_result, 32'(3 * (i - 1)));
        check("stream_count", {29'd0, count}, 32'd1);
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_last", out_result, 32'd57);
    check("stream_empty", {29'd0, count}, 32'd0);
    step();

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd1;
    in_b      = 32'd2;
    in_sel    = 4'd0;
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_count", {29'd0, count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_count", {29'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
